// File: rtl/queued_insn_decoder_if.sv
// Decoded-instruction types, table lookups and the decoder bus interface.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; the interface carries fifo_rd_en/fifo_empty and valid/ready.
// Ports (interface): fifo_rd_en, fifo_rd_data, fifo_empty on the byte side;
// instruction, valid, ready on the decoded side. master = decoder, slave = peer.

package queued_insn_decoder_pkg;

    typedef enum logic [1:0] {
        REP_PREFIX_NONE = 2'd0,
        REP_PREFIX_E    = 2'd1,
        REP_PREFIX_NE   = 2'd2
    } rep_prefix_t;

    // Encoding matches bits [4:3] of the segment-override prefix byte.
    typedef enum logic [1:0] {
        SEG_ES = 2'd0,
        SEG_CS = 2'd1,
        SEG_SS = 2'd2,
        SEG_DS = 2'd3
    } segment_t;

    typedef struct packed {
        logic [7:0]       opcode;
        logic [7:0]       mod_rm;
        rep_prefix_t      rep;
        segment_t         segment;
        logic             has_segment_override;
        logic             lock;
        logic [1:0][15:0] immediates;
        logic [15:0]      displacement;
        logic             has_modrm;
        logic [3:0]       length;
        logic             invalid;
    } Instruction;

    function automatic logic insn_has_modrm(input logic [7:0] op);
        logic r;
        // ALU r/m forms: 00-03, 08-0B, ... 38-3B
        r = (op[7:6] == 2'b00) && (op[2] == 1'b0);
        case (op) inside
            8'h62, 8'h69, 8'h6b, [8'h80:8'h8f], 8'hc0, 8'hc1, [8'hc4:8'hc7],
            [8'hd0:8'hd3], [8'hd8:8'hdf], 8'hf6, 8'hf7, 8'hfe, 8'hff: r = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // mod_rm only matters for the F6/F7 group, where only TEST (reg=000) has an immediate.
    function automatic logic [1:0] insn_immed_count(input logic [7:0] op, input logic [7:0] mod_rm);
        logic [1:0] r;
        r = ((op[7:6] == 2'b00) && ((op[2:0] == 3'd4) || (op[2:0] == 3'd5))) ? 2'd1 : 2'd0;
        case (op) inside
            [8'h68:8'h6b], [8'h70:8'h7f], [8'h80:8'h83], [8'ha0:8'ha3], 8'ha8, 8'ha9,
            [8'hb0:8'hbf], 8'hc0, 8'hc1, 8'hc2, 8'hc6, 8'hc7, 8'hca, 8'hcd, 8'hd4, 8'hd5,
            [8'he0:8'he9], 8'heb: r = 2'd1;
            8'h9a, 8'hc8, 8'hea: r = 2'd2;
            8'hf6, 8'hf7: r = (mod_rm[5:3] == 3'b000) ? 2'd1 : 2'd0;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic insn_immed_is_8bit(input logic [7:0] op, input logic idx);
        logic r;
        // AL,imm8 vs AX,imm16 in the ALU accumulator forms
        r = (op[7:6] == 2'b00) && !op[0];
        case (op) inside
            8'h6a, 8'h6b, [8'h70:8'h7f], 8'h80, 8'h82, 8'h83, 8'ha8, [8'hb0:8'hb7],
            8'hc0, 8'hc1, 8'hc6, 8'hcd, 8'hd4, 8'hd5, [8'he0:8'he7], 8'heb, 8'hf6: r = 1'b1;
            8'hc8: r = idx;   // ENTER: imm16 frame size, then imm8 nesting level
            default: ;
        endcase
        return r;
    endfunction

endpackage

interface queued_insn_decoder_if;
    import queued_insn_decoder_pkg::*;

    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    Instruction instruction;
    logic       valid;
    logic       ready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output instruction,
        output valid,
        input  ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  instruction,
        input  valid,
        output ready
    );
endinterface

// File: rtl/queued_insn_decoder.sv
// Byte-serial 8086 instruction decoder feeding an OUT_DEPTH-entry circular queue.
// Latency: one byte consumed per cycle; entry visible (valid) 1 cycle after its last byte.
// Backpressure: stops popping the byte FIFO when the queue is full and not being popped.
// Ports: clk, reset (sync, active-high), flush, bus (queued_insn_decoder_if.master),
// insn_count (only when DECODER_STATS_EN is defined: pushes since reset, wraps at 2^32).

module queued_insn_decoder
    import queued_insn_decoder_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int MAX_LEN   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    queued_insn_decoder_if.master bus
`ifdef DECODER_STATS_EN
    ,
    output logic [31:0]           insn_count
`endif
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {
        OPCODE, MODRM, DISP_LO, DISP_HI, IMM0_LO, IMM0_HI, IMM1_LO, IMM1_HI
    } state_t;

    state_t        state_q, state_d, step_state;
    Instruction    cur_q, cur_d, nxt, entry;
    logic          push, pop, done;
    logic [1:0]    imm_cnt;
    logic [7:0]    b;
    Instruction    mem [OUT_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign b               = bus.fifo_rd_data;
    assign bus.valid       = (occupancy != '0);
    assign bus.instruction = mem[rd_ptr];
    assign pop             = bus.valid && bus.ready;
    // A full queue may still take a byte when the head leaves in the same cycle.
    assign bus.fifo_rd_en  = !reset && !flush && !bus.fifo_empty &&
                             ((occupancy < CW'(OUT_DEPTH)) || pop);

    always_comb begin
        nxt        = cur_q;
        nxt.length = cur_q.length + 4'd1;
        step_state = state_q;
        done       = 1'b0;
        // Valid once mod_rm has been captured; MODRM itself uses the live byte.
        imm_cnt    = insn_immed_count(cur_q.opcode, cur_q.mod_rm);

        case (state_q)
            OPCODE: begin
                case (b)
                    8'h26, 8'h2e, 8'h36, 8'h3e: begin
                        nxt.has_segment_override = 1'b1;
                        nxt.segment              = segment_t'(b[4:3]);
                    end
                    8'hf0: nxt.lock = 1'b1;
                    8'hf2: nxt.rep  = REP_PREFIX_NE;
                    8'hf3: nxt.rep  = REP_PREFIX_E;
                    default: begin
                        nxt.opcode    = b;
                        nxt.has_modrm = insn_has_modrm(b);
                        if (nxt.has_modrm)
                            step_state = MODRM;
                        else if (insn_immed_count(b, 8'h00) != 2'd0)
                            step_state = IMM0_LO;
                        else
                            done = 1'b1;
                    end
                endcase
            end
            MODRM: begin
                nxt.mod_rm = b;
                if ((b[7:6] == 2'b01) || (b[7:6] == 2'b10) ||
                    ((b[7:6] == 2'b00) && (b[2:0] == 3'b110)))
                    step_state = DISP_LO;
                else if (insn_immed_count(cur_q.opcode, b) != 2'd0)
                    step_state = IMM0_LO;
                else
                    done = 1'b1;
            end
            DISP_LO: begin
                nxt.displacement = {{8{b[7]}}, b};
                // mod==00 only reaches here for the rm==110 direct address (disp16)
                if ((cur_q.mod_rm[7:6] == 2'b10) || (cur_q.mod_rm[7:6] == 2'b00))
                    step_state = DISP_HI;
                else if (imm_cnt != 2'd0)
                    step_state = IMM0_LO;
                else
                    done = 1'b1;
            end
            DISP_HI: begin
                nxt.displacement[15:8] = b;
                if (imm_cnt != 2'd0)
                    step_state = IMM0_LO;
                else
                    done = 1'b1;
            end
            IMM0_LO: begin
                nxt.immediates[0] = {{8{b[7]}}, b};
                if (!insn_immed_is_8bit(cur_q.opcode, 1'b0))
                    step_state = IMM0_HI;
                else if (imm_cnt == 2'd2)
                    step_state = IMM1_LO;
                else
                    done = 1'b1;
            end
            IMM0_HI: begin
                nxt.immediates[0][15:8] = b;
                if (imm_cnt == 2'd2)
                    step_state = IMM1_LO;
                else
                    done = 1'b1;
            end
            IMM1_LO: begin
                nxt.immediates[1] = {{8{b[7]}}, b};
                if (insn_immed_is_8bit(cur_q.opcode, 1'b1))
                    done = 1'b1;
                else
                    step_state = IMM1_HI;
            end
            IMM1_HI: begin
                nxt.immediates[1][15:8] = b;
                done = 1'b1;
            end
            default: step_state = OPCODE;
        endcase

        state_d = state_q;
        cur_d   = cur_q;
        push    = 1'b0;
        entry   = nxt;
        if (bus.fifo_rd_en) begin
            if (done) begin
                push    = 1'b1;
                cur_d   = '0;
                state_d = OPCODE;
            end else if (nxt.length == 4'(MAX_LEN)) begin
                // MAX_LEN bytes taken with more still needed: the next byte would
                // exceed the limit, so emit now and let that byte start afresh.
                push         = 1'b1;
                entry.invalid = 1'b1;
                cur_d        = '0;
                state_d      = OPCODE;
            end else begin
                cur_d   = nxt;
                state_d = step_state;
            end
        end
        if (flush) begin
            push    = 1'b0;
            cur_d   = '0;
            state_d = OPCODE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OPCODE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                occupancy <= occupancy + CW'(1);
            else if (pop && !push)
                occupancy <= occupancy - CW'(1);
        end
    end

    // When full with push and pop together, wr_ptr == rd_ptr: the head is read
    // this cycle before the slot is overwritten at the edge.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

`ifdef DECODER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            insn_count <= '0;
        else if (push)
            insn_count <= insn_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_queued_insn_decoder.sv
// Bench for queued_insn_decoder: byte FIFO model plus an expected-entry scoreboard.
// Latency: checks valid one cycle after the last byte of an instruction.
// Backpressure: drives ready low to fill the queue and observes fifo_rd_en.

module tb_queued_insn_decoder;
    import queued_insn_decoder_pkg::*;

    localparam logic [4:0] C_MODRM = 5'b00001;
    localparam logic [4:0] C_DISP  = 5'b00010;
    localparam logic [4:0] C_IMM0  = 5'b00100;
    localparam logic [4:0] C_IMM1  = 5'b01000;
    localparam logic [4:0] C_OP    = 5'b10000;

    typedef struct {
        Instruction i;
        logic [4:0] care;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
`ifdef DECODER_STATS_EN
    logic [31:0] insn_count;
`endif

    queued_insn_decoder_if bus();

    queued_insn_decoder #(.OUT_DEPTH(2), .MAX_LEN(15)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef DECODER_STATS_EN
        ,
        .insn_count (insn_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] bytes [$];
    exp_t       exp_q [$];
    int         total = 0;
    int         bad   = 0;
    int         ent   = 0;
    exp_t       e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [3:0] len, input logic [4:0] care);
        exp_t x;
        x.i           = '0;
        x.i.opcode    = op;
        x.i.length    = len;
        x.i.has_modrm = care[0];
        x.care        = care;
        return x;
    endfunction

    task automatic drive_fifo();
        bus.fifo_empty   = (bytes.size() == 0);
        bus.fifo_rd_data = (bytes.size() == 0) ? 8'h00 : bytes[0];
    endtask

    task automatic send(input int n, input logic [39:0] v);
        for (int i = n - 1; i >= 0; i--)
            bytes.push_back(v[8*i +: 8]);
        drive_fifo();
    endtask

    task automatic check_entry();
        Instruction a;
        exp_t       x;
        a = bus.instruction;
        if (exp_q.size() == 0) begin
            chk("unexpected_pop", 32'd1, 32'd0);
            return;
        end
        x = exp_q.pop_front();
        chk($sformatf("e%0d_len", ent), 32'(a.length), 32'(x.i.length));
        chk($sformatf("e%0d_invalid", ent), 32'(a.invalid), 32'(x.i.invalid));
        chk($sformatf("e%0d_lock", ent), 32'(a.lock), 32'(x.i.lock));
        chk($sformatf("e%0d_rep", ent), 32'(a.rep), 32'(x.i.rep));
        chk($sformatf("e%0d_segovr", ent), 32'(a.has_segment_override), 32'(x.i.has_segment_override));
        if (x.i.has_segment_override)
            chk($sformatf("e%0d_seg", ent), 32'(a.segment), 32'(x.i.segment));
        if (x.care[4]) begin
            chk($sformatf("e%0d_op", ent), 32'(a.opcode), 32'(x.i.opcode));
            chk($sformatf("e%0d_hasmodrm", ent), 32'(a.has_modrm), 32'(x.i.has_modrm));
        end
        if (x.care[0]) chk($sformatf("e%0d_modrm", ent), 32'(a.mod_rm), 32'(x.i.mod_rm));
        if (x.care[1]) chk($sformatf("e%0d_disp", ent), 32'(a.displacement), 32'(x.i.displacement));
        if (x.care[2]) chk($sformatf("e%0d_imm0", ent), 32'(a.immediates[0]), 32'(x.i.immediates[0]));
        if (x.care[3]) chk($sformatf("e%0d_imm1", ent), 32'(a.immediates[1]), 32'(x.i.immediates[1]));
        ent++;
    endtask

    // One clock: sample at negedge, let the edge happen, update the byte FIFO model.
    task automatic step();
        logic consumed;
        @(negedge clk);
        if (bus.valid && bus.ready)
            check_entry();
        consumed = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (consumed && bytes.size() != 0)
            void'(bytes.pop_front());
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bytes.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(bytes.size() + exp_q.size()), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk              = 1'b0;
        reset            = 1'b1;
        flush            = 1'b0;
        bus.ready        = 1'b1;
        bus.fifo_empty   = 1'b0;
        bus.fifo_rd_data = 8'h90;

        // Reset: no byte reads even with data available, queue empty
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_fifo();
        #1;
        chk("post_rst_valid", 32'(bus.valid), 32'd0);
`ifdef DECODER_STATS_EN
        chk("rst_count", insn_count, 32'd0);
`endif

        // NOP: valid one cycle after the consume
        send(1, 40'h90);
        exp_q.push_back(mk(8'h90, 4'd1, C_OP));
        step();
        chk("lat_valid", 32'(bus.valid), 32'd1);
        drain(50);

        // CS override, mod=01 disp8 sign-extended
        send(4, 40'h2e8b47f0);
        e = mk(8'h8b, 4'd4, C_OP | C_MODRM | C_DISP);
        e.i.mod_rm = 8'h47; e.i.displacement = 16'hfff0;
        e.i.has_segment_override = 1'b1; e.i.segment = SEG_CS;
        exp_q.push_back(e);

        // ENTER imm16 + imm8, then REP MOVSB with no leaked override
        send(4, 40'hc8100002);
        e = mk(8'hc8, 4'd4, C_OP | C_IMM0 | C_IMM1);
        e.i.immediates[0] = 16'h0010; e.i.immediates[1] = 16'h0002;
        exp_q.push_back(e);
        send(2, 40'hf3a4);
        e = mk(8'ha4, 4'd2, C_OP); e.i.rep = REP_PREFIX_E;
        exp_q.push_back(e);

        // Mixed patterns: imm16, sign-extended imm8, disp16 forms, TEST imm8, lock/repne, far jump
        send(4, 40'h81c33412);
        e = mk(8'h81, 4'd4, C_OP | C_MODRM | C_IMM0);
        e.i.mod_rm = 8'hc3; e.i.immediates[0] = 16'h1234;
        exp_q.push_back(e);
        send(3, 40'h83c3ff);
        e = mk(8'h83, 4'd3, C_OP | C_MODRM | C_IMM0);
        e.i.mod_rm = 8'hc3; e.i.immediates[0] = 16'hffff;
        exp_q.push_back(e);
        send(4, 40'h8b863412);
        e = mk(8'h8b, 4'd4, C_OP | C_MODRM | C_DISP);
        e.i.mod_rm = 8'h86; e.i.displacement = 16'h1234;
        exp_q.push_back(e);
        send(4, 40'h8b067856);
        e = mk(8'h8b, 4'd4, C_OP | C_MODRM | C_DISP);
        e.i.mod_rm = 8'h06; e.i.displacement = 16'h5678;
        exp_q.push_back(e);
        send(5, 40'hf6063412aa);
        e = mk(8'hf6, 4'd5, C_OP | C_MODRM | C_DISP | C_IMM0);
        e.i.mod_rm = 8'h06; e.i.displacement = 16'h1234; e.i.immediates[0] = 16'hffaa;
        exp_q.push_back(e);
        send(4, 40'hc646fe7f);
        e = mk(8'hc6, 4'd4, C_OP | C_MODRM | C_DISP | C_IMM0);
        e.i.mod_rm = 8'h46; e.i.displacement = 16'hfffe; e.i.immediates[0] = 16'h007f;
        exp_q.push_back(e);
        send(3, 40'hf0f2a6);
        e = mk(8'ha6, 4'd3, C_OP); e.i.lock = 1'b1; e.i.rep = REP_PREFIX_NE;
        exp_q.push_back(e);
        send(5, 40'hea001000f0);
        e = mk(8'hea, 4'd5, C_OP | C_IMM0 | C_IMM1);
        e.i.immediates[0] = 16'h1000; e.i.immediates[1] = 16'hf000;
        exp_q.push_back(e);
        drain(200);

        // Backpressure: queue of 2 fills, then one pop admits exactly one push
        bus.ready = 1'b0;
        send(5, 40'h9090909090);
        repeat (5) exp_q.push_back(mk(8'h90, 4'd1, C_OP));
        repeat (4) step();
        #1;
        chk("bp_rd_en_low", 32'(bus.fifo_rd_en), 32'd0);
        chk("bp_bytes_left", 32'(bytes.size()), 32'd3);
        chk("bp_valid", 32'(bus.valid), 32'd1);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        #1;
        chk("bp_one_push", 32'(bytes.size()), 32'd2);
        chk("bp_one_pop", 32'(exp_q.size()), 32'd4);
        chk("bp_rd_en_again", 32'(bus.fifo_rd_en), 32'd0);
        bus.ready = 1'b1;
        drain(100);

        // Length overflow: 15 prefixes emit an invalid entry; the 16th starts afresh
        repeat (16) send(1, 40'h26);
        send(1, 40'h90);
        e = mk(8'h00, 4'd15, 5'b00000);
        e.i.invalid = 1'b1; e.i.has_segment_override = 1'b1; e.i.segment = SEG_ES;
        exp_q.push_back(e);
        e = mk(8'h90, 4'd2, C_OP);
        e.i.has_segment_override = 1'b1; e.i.segment = SEG_ES;
        exp_q.push_back(e);
        drain(100);

        // Flush in DISP_HI with one entry queued
        bus.ready = 1'b0;
        send(4, 40'h908b8634);
        repeat (5) step();
        chk("pre_flush_valid", 32'(bus.valid), 32'd1);
        send(3, 40'hb83412);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(bus.valid), 32'd0);
        chk("flush_no_consume", 32'(bytes.size()), 32'd3);
        bus.ready = 1'b1;
        e = mk(8'hb8, 4'd3, C_OP | C_IMM0);
        e.i.immediates[0] = 16'h1234;
        exp_q.push_back(e);
        drain(100);

        // Reset mid-instruction discards the partial decode
        send(2, 40'h8b86);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst2_valid", 32'(bus.valid), 32'd0);
`ifdef DECODER_STATS_EN
        chk("rst2_count", insn_count, 32'd0);
`endif
        send(1, 40'h90);
        exp_q.push_back(mk(8'h90, 4'd1, C_OP));
        drain(50);
`ifdef DECODER_STATS_EN
        chk("count_after_one", insn_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
